wb_bus_arbiter: RTL

- Two-master, one-slave Wishbone arbiter sharing the single memory port between the instruction-fetch stage (master 0) and the memory/data stage (master 1).
- Grant is registered and held for the full Wishbone cycle, so multi-beat cycles are never split.
- Sits between the pipeline stages' Wishbone units and the external memory/bus interconnect.

---
 rtl/wb_bus_arbiter.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/wb_bus_arbiter.sv
// wb_bus_arbiter: two-master / one-slave Wishbone arbiter.
// Master 0 is instruction fetch and master 1 is the data stage. The grant is
// registered and held until the owner drops cyc, so multi-beat cycles are
// never split. When the owner releases, the bus is handed straight to the
// other master if it is requesting; there is no idle cycle in between.
// Optional macro WB_ARB_TIMEOUT_EN: a stalled slave produces a forced one-cycle
// error after TIMEOUT_CYCLES strobed cycles without ack/err.
module wb_bus_arbiter #(
  parameter int unsigned DATA_PRIORITY  = 1,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_addr_o,
  output logic [31:0] s_dat_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  input  logic        s_err_i,
  output logic [1:0]  grant_o
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("wb_bus_arbiter: TIMEOUT_CYCLES must be >= 2");
  end

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t state;
  logic   req0;
  logic   req1;
  logic   tmo;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt;
  logic          blk0;
  logic          blk1;

  assign tmo  = (state != IDLE) && (cnt == CW'(TIMEOUT_CYCLES));
  // A master cut off by a timeout must drop cyc before it can be granted again.
  assign req0 = m0_cyc_i & ~blk0;
  assign req1 = m1_cyc_i & ~blk1;

  // Stall counter: cleared whenever a new grant can start or the slave answers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt <= '0;
    end else if ((state == IDLE) || tmo || s_ack_i || s_err_i ||
                 ((state == GNT0) && !m0_cyc_i) ||
                 ((state == GNT1) && !m1_cyc_i)) begin
      cnt <= '0;
    end else if (s_stb_o) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Block flags: set on a forced error, cleared once that master drops cyc.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      blk0 <= 1'b0;
      blk1 <= 1'b0;
    end else begin
      if (tmo && (state == GNT0))
        blk0 <= 1'b1;
      else if (!m0_cyc_i)
        blk0 <= 1'b0;
      if (tmo && (state == GNT1))
        blk1 <= 1'b1;
      else if (!m1_cyc_i)
        blk1 <= 1'b0;
    end
  end
`else
  assign tmo  = 1'b0;
  assign req0 = m0_cyc_i;
  assign req1 = m1_cyc_i;
`endif

  // Arbitration FSM; grant_o is registered alongside the state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      grant_o <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (req0 && req1) begin
            if (DATA_PRIORITY != 0) begin
              state   <= GNT1;
              grant_o <= 2'b10;
            end else begin
              state   <= GNT0;
              grant_o <= 2'b01;
            end
          end else if (req0) begin
            state   <= GNT0;
            grant_o <= 2'b01;
          end else if (req1) begin
            state   <= GNT1;
            grant_o <= 2'b10;
          end
        end
        GNT0: begin
          if (tmo) begin
            state   <= IDLE;
            grant_o <= 2'b00;
          end else if (!m0_cyc_i) begin
            if (req1) begin
              state   <= GNT1;
              grant_o <= 2'b10;
            end else begin
              state   <= IDLE;
              grant_o <= 2'b00;
            end
          end
        end
        GNT1: begin
          if (tmo) begin
            state   <= IDLE;
            grant_o <= 2'b00;
          end else if (!m1_cyc_i) begin
            if (req0) begin
              state   <= GNT0;
              grant_o <= 2'b01;
            end else begin
              state   <= IDLE;
              grant_o <= 2'b00;
            end
          end
        end
        default: begin
          state   <= IDLE;
          grant_o <= 2'b00;
        end
      endcase
    end
  end

  // Combinational bus mux: owner drives the slave, slave responses return to the owner only.
  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_sel_o  = '0;
    s_addr_o = '0;
    s_dat_o  = '0;
    m0_dat_o = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_dat_o = '0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    case (state)
      GNT0: begin
        s_cyc_o  = m0_cyc_i & ~tmo;
        s_stb_o  = m0_stb_i & ~tmo;
        s_we_o   = m0_we_i;
        s_sel_o  = m0_sel_i;
        s_addr_o = m0_addr_i;
        s_dat_o  = m0_dat_i;
        m0_dat_o = s_dat_i;
        m0_ack_o = s_ack_i & ~tmo;
        m0_err_o = s_err_i | tmo;
      end
      GNT1: begin
        s_cyc_o  = m1_cyc_i & ~tmo;
        s_stb_o  = m1_stb_i & ~tmo;
        s_we_o   = m1_we_i;
        s_sel_o  = m1_sel_i;
        s_addr_o = m1_addr_i;
        s_dat_o  = m1_dat_i;
        m1_dat_o = s_dat_i;
        m1_ack_o = s_ack_i & ~tmo;
        m1_err_o = s_err_i | tmo;
      end
      default: ;
    endcase
  end

endmodule
